// File: rtl/pipe_stage_chain.sv
// -----------------------------------------------------------------------------
// pipe_stage_chain
// Chain of DEPTH pipeline registers carrying a control payload and a data
// payload per stage, with valid/ready handshaking, bubble collapse, flush
// and a registered occupancy count.
//
// Ports
//   clk        : single clock, rising edge
//   reset      : synchronous active-high reset (overrides everything)
//   flush      : kill every in-flight entry and drop the presented entry
//   in_valid   : entry presented on in_ctrl / in_data
//   in_ctrl    : control payload of presented entry   [CTRL_W]
//   in_data    : data payload of presented entry      [DATA_W]
//   in_ready   : presented entry is accepted at the next edge
//   out_valid  : last stage holds a valid entry
//   out_ctrl   : control payload of last stage (zero when invalid)
//   out_data   : data payload of last stage
//   out_ready  : consumer takes the last-stage entry at the next edge
//   occupancy  : number of valid stages              [$clog2(DEPTH+1)]
// -----------------------------------------------------------------------------
module pipe_stage_chain #(
   parameter  int DATA_W = 64,
   parameter  int CTRL_W = 8,
   parameter  int DEPTH  = 4,
   localparam int OCC_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic [OCC_W-1:0]  occupancy
);

   logic [DEPTH-1:0]  valid_r;
   logic [CTRL_W-1:0] ctrl_r [DEPTH];
   logic [DATA_W-1:0] data_r [DEPTH];
   logic [OCC_W-1:0]  occ_r;

   // ready_s[i] is the readiness of stage i; ready_s[DEPTH] is the consumer.
   logic [DEPTH:0]    ready_s;
   logic [DEPTH-1:0]  src_valid_s;
   logic [CTRL_W-1:0] src_ctrl_s [DEPTH];
   logic [DATA_W-1:0] src_data_s [DEPTH];
   logic              push_s;
   logic              pop_s;

   // Combinational readiness chain: an empty stage is always ready, so bubbles
   // close even while the consumer stalls.
   always_comb begin
      ready_s        = {(DEPTH + 1){1'b0}};
      ready_s[DEPTH] = out_ready;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         ready_s[i] = !valid_r[i] || ready_s[i + 1];
      end
   end

   // Source of each stage: the external input for stage 0, else the predecessor.
   always_comb begin
      src_valid_s   = {DEPTH{1'b0}};
      src_valid_s[0] = in_valid;
      src_ctrl_s[0]  = in_ctrl;
      src_data_s[0]  = in_data;
      for (int i = 1; i < DEPTH; i++) begin
         src_valid_s[i] = valid_r[i - 1];
         src_ctrl_s[i]  = ctrl_r[i - 1];
         src_data_s[i]  = data_r[i - 1];
      end
   end

   // Handshake decode; reset and flush both block acceptance.
   always_comb begin
      in_ready = ready_s[0] && !flush && !reset;
      push_s   = in_valid && in_ready;
      pop_s    = valid_r[DEPTH - 1] && out_ready;
   end

   // Stage registers: reset clears all, flush clears valid/ctrl only,
   // otherwise each ready stage loads from its source and a stalled one holds.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_r <= {DEPTH{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            ctrl_r[i] <= {CTRL_W{1'b0}};
            data_r[i] <= {DATA_W{1'b0}};
         end
      end else if (flush) begin
         valid_r <= {DEPTH{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            ctrl_r[i] <= {CTRL_W{1'b0}};
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (ready_s[i]) begin
               valid_r[i] <= src_valid_s[i];
               if (src_valid_s[i]) begin
                  ctrl_r[i] <= src_ctrl_s[i];
                  data_r[i] <= src_data_s[i];
               end else begin
                  // Invalid entries carry no control; data keeps its old value.
                  ctrl_r[i] <= {CTRL_W{1'b0}};
               end
            end
         end
      end
   end

   // Occupancy counter tracking accepts and pops.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         occ_r <= {OCC_W{1'b0}};
      end else begin
         case ({push_s, pop_s})
            2'b10:   occ_r <= occ_r + OCC_W'(1);
            2'b01:   occ_r <= occ_r - OCC_W'(1);
            default: occ_r <= occ_r;
         endcase
      end
   end

   assign out_valid = valid_r[DEPTH - 1];
   assign out_ctrl  = ctrl_r[DEPTH - 1];
   assign out_data  = data_r[DEPTH - 1];
   assign occupancy = occ_r;

endmodule
